serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits, minimum 2.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: minuend; captured when start is accepted.
REQ-006 SHALL have port b, input, WIDTH bits: subtrahend; captured when start is accepted.
REQ-007 SHALL have port bin, input, 1 bit: borrow-in; captured when start is accepted.
REQ-008 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 SHALL have port diff, output, WIDTH bits: the result of a - b - bin, modulo 2^WIDTH.
REQ-011 SHALL have port bout, output, 1 bit: final borrow-out.
REQ-012 SHALL have port ovf, output, 1 bit: two's-complement signed overflow flag.

Function
REQ-013 SHALL implement an FSM with three states, IDLE, RUN and DONE, held in registers.
REQ-014 In IDLE, start=1 SHALL capture a, b and bin into internal shift registers, clear the bit counter, and go to RUN on the next edge.
REQ-015 In RUN, each cycle SHALL process one bit, LSB first, using a full-subtractor cell on the operand LSBs and the borrow flip-flop:
- d = a0 ^ b0 ^ br
- br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
REQ-016 In RUN, each cycle SHALL shift d into the result register from the MSB end, shift both operands right by one, and increment the counter.
REQ-017 After exactly WIDTH RUN cycles the FSM SHALL enter DONE; on entry, diff, bout and ovf SHALL be loaded from the result register and the borrow flip-flop.
REQ-018 DONE SHALL last exactly one cycle, with done=1, then return to IDLE.
REQ-019 Latency: start high in cycle 0 SHALL give busy high in cycles 1..WIDTH and done high in cycle WIDTH+1 only.
REQ-020 diff, bout and ovf SHALL hold their last loaded value until the next DONE entry, and SHALL NOT change during RUN.
REQ-021 start SHALL be ignored while in RUN or DONE; the operation in flight SHALL be unaffected by it.
REQ-022 start held high continuously SHALL begin a new operation on every IDLE visit, i.e. one result every WIDTH+2 cycles.
REQ-023 Changes on a, b or bin after capture SHALL NOT affect the operation in flight.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, clear the operand registers, the result register, the counter and the borrow flip-flop, and drive busy=0, done=0, diff=0, bout=0 and ovf=0.
REQ-025 rst during RUN or DONE SHALL abort the operation with no done pulse; the first start after rst is released SHALL operate normally.
REQ-026 rst SHALL take priority over start in the same cycle.

Configuration
REQ-027 When macro SERIAL_SUBTRACTOR_OVF_EN is defined, ovf SHALL be loaded at DONE entry as (borrow into the MSB cell) XOR (borrow out of the MSB cell).
REQ-028 When SERIAL_SUBTRACTOR_OVF_EN is undefined, ovf SHALL be tied to 0, no overflow logic SHALL be synthesized, and all other behaviour SHALL be unchanged.

Verification
REQ-029 The bench SHALL check: WIDTH=8, a=0x05, b=0x03, bin=0, start pulsed in cycle 0 -> busy high in cycles 1-8, done high in cycle 9 only, diff=0x02, bout=0.
REQ-030 The bench SHALL check: a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-031 The bench SHALL check: a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, with ovf=1 when SERIAL_SUBTRACTOR_OVF_EN is defined and ovf=0 when it is not.
REQ-032 The bench SHALL check: start=1 with a=0x10, b=0x01 in cycle 0, then start=1 with a=0xFF, b=0x00 in cycle 3 -> first result 0x0F in cycle 9, and the second request ignored.
REQ-033 The bench SHALL check: rst pulsed in cycle 4 of a run -> no done pulse, all outputs 0; then a=0x0A, b=0x0A -> diff=0x00, bout=0, done 9 cycles after start.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per cycle; result presented with a one-cycle done pulse.
// Define SERIAL_SUBTRACTOR_OVF_EN to build the signed-overflow flag; otherwise ovf is tied low.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d, br_nxt, last;

  // full-subtractor cell on the operand LSBs
  assign d      = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // outputs load on the RUN->DONE edge so they are valid while done is high
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr <= a;
          b_sr <= b;
          br   <= bin;
          cnt  <= '0;
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {d, res_sr[WIDTH-1:1]};
          br     <= br_nxt;
          cnt    <= cnt + 1'b1;
          if (last) begin
            diff <= {d, res_sr[WIDTH-1:1]};
            bout <= br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // in the MSB cycle br is the borrow into the sign cell, br_nxt the borrow out of it
  always_ff @(posedge clk) begin
    if (rst)                        ovf <= 1'b0;
    else if (state == RUN && last)  ovf <= br ^ br_nxt;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
